// File: rtl/bram_master.sv
// bram_master: initiator for a single-port block RAM with a 1-cycle registered read.
// Takes single-beat writes and incrementing read bursts over a valid/ready request
// channel, and returns one beat at a time on a back-pressurable response channel.
// At most one RAM access is in flight. The RAM is only enabled while the state is ISSUE.
module bram_master #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9,
  parameter int LEN_BITS      = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [RAM_ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]      req_len,
  input  logic [RAM_WIDTH-1:0]     req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [RAM_WIDTH-1:0]     rsp_data,
  output logic                     rsp_last,
  output logic                     busy,
  output logic                     ram_enable,
  output logic                     ram_write_enable,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  output logic [RAM_WIDTH-1:0]     ram_wdata,
  input  logic [RAM_WIDTH-1:0]     ram_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ZERO = {RAM_ADDR_BITS{1'b0}};
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE  = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0]      LEN_ZERO  = {LEN_BITS{1'b0}};
  localparam logic [LEN_BITS-1:0]      LEN_ONE   = {{(LEN_BITS-1){1'b0}}, 1'b1};
  localparam logic [RAM_WIDTH-1:0]     DATA_ZERO = {RAM_WIDTH{1'b0}};

  logic [1:0]               state_r;
  logic                     write_r;
  logic [RAM_ADDR_BITS-1:0] cur_addr_r;
  logic [LEN_BITS-1:0]      beats_left_r;
  logic [RAM_WIDTH-1:0]     wdata_r;

  // Incrementing burst address; wraps silently at the top of the RAM.
  function automatic logic [RAM_ADDR_BITS-1:0] next_addr(input logic [RAM_ADDR_BITS-1:0] a);
    return a + ADDR_ONE;
  endfunction

  // Transaction FSM; every output is registered and updated with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= IDLE;
      write_r          <= 1'b0;
      cur_addr_r       <= ADDR_ZERO;
      beats_left_r     <= LEN_ZERO;
      wdata_r          <= DATA_ZERO;
      req_ready        <= 1'b1;
      busy             <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_data         <= DATA_ZERO;
      rsp_last         <= 1'b0;
      ram_enable       <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_address      <= ADDR_ZERO;
      ram_wdata        <= DATA_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            write_r          <= req_write;
            cur_addr_r       <= req_addr;
            beats_left_r     <= req_write ? LEN_ZERO : req_len;
            wdata_r          <= req_wdata;
            req_ready        <= 1'b0;
            busy             <= 1'b1;
            state_r          <= ISSUE;
            // The RAM pins take their ISSUE values on the same edge as the state.
            ram_enable       <= 1'b1;
            ram_write_enable <= req_write;
            ram_address      <= req_addr;
            ram_wdata        <= req_wdata;
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ISSUE: begin
          ram_enable       <= 1'b0;
          ram_write_enable <= 1'b0;
          ram_address      <= ADDR_ZERO;
          ram_wdata        <= DATA_ZERO;
          if (write_r) begin
            rsp_valid <= 1'b1;
            rsp_data  <= DATA_ZERO;
            rsp_last  <= 1'b1;
            state_r   <= RESP;
          end else begin
            state_r   <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= ram_rdata;
          rsp_last  <= (beats_left_r == LEN_ZERO);
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              state_r   <= IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              cur_addr_r       <= next_addr(cur_addr_r);
              beats_left_r     <= beats_left_r - LEN_ONE;
              state_r          <= ISSUE;
              ram_enable       <= 1'b1;
              ram_write_enable <= write_r;
              ram_address      <= next_addr(cur_addr_r);
              ram_wdata        <= wdata_r;
            end
          end else begin
            rsp_valid <= rsp_valid;
          end
        end
        default: begin
          state_r          <= IDLE;
          req_ready        <= 1'b1;
          busy             <= 1'b0;
          rsp_valid        <= 1'b0;
          ram_enable       <= 1'b0;
          ram_write_enable <= 1'b0;
          ram_address      <= ADDR_ZERO;
          ram_wdata        <= DATA_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_master.sv
// Directed bench for bram_master with a behavioural RAM, a response scoreboard
// and a RAM-access scoreboard.
module tb_bram_master;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [8:0]  req_addr = 9'd0;
  logic [3:0]  req_len = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        ram_enable;
  logic        ram_write_enable;
  logic [8:0]  ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'd0;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] rsp_q[$];   // {last, data}
  logic [9:0]  ram_q[$];   // {write_enable, address}
  logic [31:0] mem [0:511];

  bram_master #(.RAM_WIDTH(32), .RAM_ADDR_BITS(9), .LEN_BITS(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .ram_enable(ram_enable), .ram_write_enable(ram_write_enable),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM with a registered read port.
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_write_enable) mem[ram_address] <= ram_wdata;
      else ram_rdata <= mem[ram_address];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response scoreboard: compares every consumed beat with the queued expectation.
  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = rsp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
        check("rsp_last", 64'(rsp_last), 64'(e[32]));
      end
    end
  end

  // RAM-access scoreboard: every enable cycle must match the next expected access.
  always @(negedge clock) begin
    if (reset_n && ram_enable) begin
      if (ram_q.size() == 0) begin
        check("ram_unexpected", 64'(ram_address), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = ram_q.pop_front();
        check("ram_address", 64'(ram_address), 64'(e[8:0]));
        check("ram_write_enable", 64'(ram_write_enable), 64'(e[9]));
      end
    end
  end

  // Queue expected RAM accesses, then present the request until accepted.
  // Returns 1 time unit after the accepting edge.
  task automatic send(input logic w, input logic [8:0] a, input logic [3:0] l, input logic [31:0] d);
    int n;
    for (int i = 0; i <= (w ? 0 : int'(l)); i++) ram_q.push_back({w, 9'(a + 9'(i))});
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) check("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_q.size() != 0 || ram_q.size() != 0) && n < 200) begin
      @(negedge clock); n++;
    end
    if (n >= 200) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp_valid(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clock); #1; n++; end
    if (n >= 20) check(name, 64'd0, 64'd1);
  endtask

  initial begin
    logic [31:0] held_data;
    logic        held_last;
    int          n;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;

    // Reset values
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_ram_enable", 64'(ram_enable), 64'd0);
    @(negedge clock); reset_n = 1'b1;

    // 1: write 0xDEADBEEF to 0x005
    rsp_q.push_back({1'b1, 32'd0});
    send(1'b1, 9'h005, 4'd0, 32'hDEADBEEF);
    check("t1_ram_enable", 64'(ram_enable), 64'd1);
    check("t1_ram_we", 64'(ram_write_enable), 64'd1);
    check("t1_ram_wdata", 64'(ram_wdata), 64'hDEADBEEF);
    check("t1_busy", 64'(busy), 64'd1);
    @(posedge clock); #1;
    check("t1_ram_enable_off", 64'(ram_enable), 64'd0);
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    wait_idle();

    // 2: read back 0x005, response two edges after acceptance
    rsp_q.push_back({1'b1, 32'hDEADBEEF});
    send(1'b0, 9'h005, 4'd0, 32'd0);
    check("t2_rsp_valid_e0", 64'(rsp_valid), 64'd0);
    @(posedge clock); #1;
    check("t2_rsp_valid_e1", 64'(rsp_valid), 64'd0);
    @(posedge clock); #1;
    check("t2_rsp_valid_e2", 64'(rsp_valid), 64'd1);
    wait_idle();
    check("t2_req_ready", 64'(req_ready), 64'd1);

    // 3: wrapping burst across the top of the address space
    for (int i = 0; i < 4; i++) begin
      rsp_q.push_back({1'b1, 32'd0});
      send(1'b1, 9'(9'h1FE + 9'(i)), 4'd0, 32'(i + 1));
      wait_idle();
    end
    rsp_q.push_back({1'b0, 32'd1});
    rsp_q.push_back({1'b0, 32'd2});
    rsp_q.push_back({1'b0, 32'd3});
    rsp_q.push_back({1'b1, 32'd4});
    send(1'b0, 9'h1FE, 4'd3, 32'd0);
    wait_idle();

    // 4: stall beat 2 for 5 cycles
    rsp_q.push_back({1'b0, 32'd1});
    rsp_q.push_back({1'b0, 32'd2});
    rsp_q.push_back({1'b0, 32'd3});
    rsp_q.push_back({1'b1, 32'd4});
    send(1'b0, 9'h1FE, 4'd3, 32'd0);
    wait_rsp_valid("t4_beat1_timeout");
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    wait_rsp_valid("t4_beat2_timeout");
    held_data = rsp_data;
    held_last = rsp_last;
    check("t4_beat2_data", 64'(held_data), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("t4_stall_valid", 64'(rsp_valid), 64'd1);
      check("t4_stall_data", 64'(rsp_data), 64'(held_data));
      check("t4_stall_last", 64'(rsp_last), 64'(held_last));
      check("t4_stall_ram_enable", 64'(ram_enable), 64'd0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // 5: reset while in CAPTURE
    send(1'b0, 9'h005, 4'd2, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    rsp_q.delete();
    ram_q.delete();
    #1;
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_rsp_data", 64'(rsp_data), 64'd0);
    check("t5_rsp_last", 64'(rsp_last), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_req_ready", 64'(req_ready), 64'd1);
    check("t5_ram_enable", 64'(ram_enable), 64'd0);
    check("t5_ram_address", 64'(ram_address), 64'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    check("t5_req_ready_after", 64'(req_ready), 64'd1);
    rsp_q.push_back({1'b1, 32'hDEADBEEF});
    send(1'b0, 9'h005, 4'd0, 32'd0);
    wait_idle();

    // 6: request held during a burst is taken on the first IDLE cycle
    rsp_q.push_back({1'b0, 32'd3});
    rsp_q.push_back({1'b1, 32'd4});
    send(1'b0, 9'h000, 4'd1, 32'd0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h010; req_len = 4'd7; req_wdata = 32'hA5A5_0F0F;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      check("t6_busy_not_ready", 64'(busy), 64'd1);
      @(negedge clock); n++;
    end
    check("t6_ready_only_idle", 64'(busy), 64'd0);
    if (n >= 100) check("t6_accept_timeout", 64'd0, 64'd1);
    ram_q.push_back({1'b1, 9'h010});
    rsp_q.push_back({1'b1, 32'd0});
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("t6_accepted_enable", 64'(ram_enable), 64'd1);
    check("t6_accepted_wdata", 64'(ram_wdata), 64'hA5A5_0F0F);
    wait_idle();
    rsp_q.push_back({1'b1, 32'hA5A5_0F0F});
    send(1'b0, 9'h010, 4'd0, 32'd0);
    wait_idle();

    check("end_rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check("end_ram_q_empty", 64'(ram_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
